// File: rtl/enigma_step_ctrl_if.sv
// Bundle of configuration, plaintext/ciphertext handshakes and datapath signals
// for the Enigma step controller.
interface enigma_step_ctrl_if;
  logic       cfg_load;
  logic [4:0] cfg_pos_l, cfg_pos_m, cfg_pos_r;
  logic       in_valid;
  logic [4:0] in_letter;
  logic       in_ready;
  logic       dp_start;
  logic [4:0] dp_letter;
  logic [4:0] dp_pos_l, dp_pos_m, dp_pos_r;
  logic [4:0] dp_result;
  logic       out_valid;
  logic [4:0] out_letter;
  logic       out_ready;
  logic [4:0] pos_l, pos_m, pos_r;
  logic       err;

  // controller side
  modport slave (
    input  cfg_load, cfg_pos_l, cfg_pos_m, cfg_pos_r,
    input  in_valid, in_letter, dp_result, out_ready,
    output in_ready, dp_start, dp_letter, dp_pos_l, dp_pos_m, dp_pos_r,
    output out_valid, out_letter, pos_l, pos_m, pos_r, err
  );

  // environment side (letter source, datapath, consumer)
  modport master (
    output cfg_load, cfg_pos_l, cfg_pos_m, cfg_pos_r,
    output in_valid, in_letter, dp_result, out_ready,
    input  in_ready, dp_start, dp_letter, dp_pos_l, dp_pos_m, dp_pos_r,
    input  out_valid, out_letter, pos_l, pos_m, pos_r, err
  );
endinterface

// File: rtl/enigma_step_ctrl.sv
// Enigma encode sequencer: accepts a letter, steps rotors (with middle-rotor
// double step), strobes the datapath, waits DP_LAT cycles, returns the result.
module enigma_step_ctrl #(
  parameter logic [4:0] NOTCH_R = 5'd22,
  parameter logic [4:0] NOTCH_M = 5'd5,
  parameter int         DP_LAT  = 2
) (
  input  logic               clk,
  input  logic               rst,
  enigma_step_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, STEP, ISSUE, WAIT, HOLD} state_t;

  state_t     state_q;
  logic [4:0] pos_l_q, pos_m_q, pos_r_q;
  logic [4:0] letter_q, out_letter_q;
  logic       dp_start_q, out_valid_q, err_q;
  logic [3:0] cnt_q;

  logic [4:0] pos_l_d, pos_m_d, pos_r_d;
  logic       cfg_ok, letter_ok;

  function automatic logic legal(input logic [4:0] p);
    return (p != 5'd0) && (p <= 5'd26);
  endfunction

  function automatic logic [4:0] inc26(input logic [4:0] p);
    return (p == 5'd26) ? 5'd1 : p + 5'd1;
  endfunction

  // Both notch tests look at pre-step values, which gives the double step.
  always_comb begin
    pos_r_d = inc26(pos_r_q);
    pos_m_d = ((pos_r_q == NOTCH_R) || (pos_m_q == NOTCH_M)) ? inc26(pos_m_q) : pos_m_q;
    pos_l_d = (pos_m_q == NOTCH_M) ? inc26(pos_l_q) : pos_l_q;
  end

  assign cfg_ok    = legal(bus.cfg_pos_l) && legal(bus.cfg_pos_m) && legal(bus.cfg_pos_r);
  assign letter_ok = legal(bus.in_letter);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pos_l_q      <= 5'd1;
      pos_m_q      <= 5'd1;
      pos_r_q      <= 5'd1;
      letter_q     <= 5'd0;
      out_letter_q <= 5'd0;
      dp_start_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cfg_load) begin
            if (cfg_ok) begin
              pos_l_q <= bus.cfg_pos_l;
              pos_m_q <= bus.cfg_pos_m;
              pos_r_q <= bus.cfg_pos_r;
            end else begin
              err_q <= 1'b1;
            end
          end else if (bus.in_valid) begin
            // illegal letters are consumed without touching the datapath
            if (letter_ok) begin
              letter_q <= bus.in_letter;
              state_q  <= STEP;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        STEP: begin
          pos_l_q    <= pos_l_d;
          pos_m_q    <= pos_m_d;
          pos_r_q    <= pos_r_d;
          dp_start_q <= 1'b1;
          state_q    <= ISSUE;
        end
        ISSUE: begin
          dp_start_q <= 1'b0;
          cnt_q      <= 4'(DP_LAT);
          state_q    <= WAIT;
        end
        WAIT: begin
          if (cnt_q == 4'd1) begin
            out_letter_q <= bus.dp_result;
            out_valid_q  <= 1'b1;
            state_q      <= HOLD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state_q == IDLE) && !bus.cfg_load;
  assign bus.dp_start   = dp_start_q;
  assign bus.dp_letter  = letter_q;
  assign bus.dp_pos_l   = pos_l_q;
  assign bus.dp_pos_m   = pos_m_q;
  assign bus.dp_pos_r   = pos_r_q;
  assign bus.pos_l      = pos_l_q;
  assign bus.pos_m      = pos_m_q;
  assign bus.pos_r      = pos_r_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_letter = out_letter_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Randomized bench for enigma_step_ctrl with a DP_LAT-deep datapath stub
// (result = letter+1, wrapping Z to A) and an arithmetic rotor model.
module tb_enigma_step_ctrl;
  localparam int DP_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   ml, mm, mr;
  int   last_acc;

  enigma_step_ctrl_if bus();

  enigma_step_ctrl #(.NOTCH_R(5'd22), .NOTCH_M(5'd5), .DP_LAT(DP_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // datapath stub: result appears exactly DP_LAT cycles after the strobe is sampled
  logic [4:0] pipe [DP_LAT];
  always @(posedge clk) begin
    pipe[0] <= bus.dp_start ? ((bus.dp_letter == 5'd26) ? 5'd1 : bus.dp_letter + 5'd1) : 5'd0;
    for (int i = 1; i < DP_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.dp_result = pipe[DP_LAT-1];

  function automatic int nxt(input int p);
    return p % 26 + 1;
  endfunction

  task automatic model_step();
    bit sm, sl;
    sm = (mr == 22) || (mm == 5);
    sl = (mm == 5);
    mr = nxt(mr);
    if (sm) mm = nxt(mm);
    if (sl) ml = nxt(ml);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg(input int l, input int m, input int r);
    bus.cfg_load = 1'b1;
    bus.cfg_pos_l = 5'(l); bus.cfg_pos_m = 5'(m); bus.cfg_pos_r = 5'(r);
    tick();
    bus.cfg_load = 1'b0;
    if (l >= 1 && l <= 26 && m >= 1 && m <= 26 && r >= 1 && r <= 26) begin
      ml = l; mm = m; mr = r;
    end
  endtask

  // mode 0 normal, 1 cfg_load pulse during WAIT, 2 rst pulse during WAIT
  task automatic send(input int l, input int bp, input int mode);
    int t, acc, exp_out;
    bit got, bad;
    bus.out_ready = (bp == 0);
    t = 0;
    while (!bus.in_ready && t < 50) begin tick(); t++; end
    checks++;
    if (!bus.in_ready) begin
      failures++; $display("FAIL in_ready_timeout got=0 exp=1"); return;
    end
    bus.in_valid = 1'b1; bus.in_letter = 5'(l);
    tick();
    acc = cyc; bus.in_valid = 1'b0;
    model_step();
    exp_out = l % 26 + 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin tick(); if (bus.dp_start) got = 1; end
    checks++;
    if (!got || cyc != acc + 1)
      begin failures++; $display("FAIL dp_start_time got=%0d exp=1 seen=%0d", cyc - acc, got); end
    checks++;
    if ({bus.dp_pos_l, bus.dp_pos_m, bus.dp_pos_r} !== {5'(ml), 5'(mm), 5'(mr)})
      begin failures++; $display("FAIL dp_pos got=%0d/%0d/%0d exp=%0d/%0d/%0d", bus.dp_pos_l, bus.dp_pos_m, bus.dp_pos_r, ml, mm, mr); end
    checks++;
    if (bus.dp_letter !== 5'(l))
      begin failures++; $display("FAIL dp_letter got=%0d exp=%0d", bus.dp_letter, l); end
    if (mode == 2) begin
      tick(); rst = 1'b1; tick(); rst = 1'b0;
      ml = 1; mm = 1; mr = 1;
      bad = 0;
      for (int i = 0; i < DP_LAT + 3; i++) begin
        if (bus.out_valid || bus.dp_start) bad = 1;
        tick();
      end
      checks++;
      if (bad) begin failures++; $display("FAIL abort_no_output got=1 exp=0"); end
      checks++;
      if ({bus.pos_l, bus.pos_m, bus.pos_r} !== {5'd1, 5'd1, 5'd1})
        begin failures++; $display("FAIL abort_pos got=%0d/%0d/%0d exp=1/1/1", bus.pos_l, bus.pos_m, bus.pos_r); end
      bus.out_ready = 1'b1;
      return;
    end
    if (mode == 1) begin
      tick();
      bus.cfg_load = 1'b1; bus.cfg_pos_l = 5'd3; bus.cfg_pos_m = 5'd3; bus.cfg_pos_r = 5'd3;
      tick();
      bus.cfg_load = 1'b0;
    end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin tick(); if (bus.out_valid) got = 1; end
    checks++;
    if (!got || cyc != acc + DP_LAT + 2)
      begin failures++; $display("FAIL out_valid_time got=%0d exp=%0d seen=%0d", cyc - acc, DP_LAT + 2, got); end
    checks++;
    if (bus.out_letter !== 5'(exp_out))
      begin failures++; $display("FAIL out_letter got=%0d exp=%0d", bus.out_letter, exp_out); end
    checks++;
    if ({bus.pos_l, bus.pos_m, bus.pos_r} !== {5'(ml), 5'(mm), 5'(mr)})
      begin failures++; $display("FAIL pos_hold got=%0d/%0d/%0d exp=%0d/%0d/%0d", bus.pos_l, bus.pos_m, bus.pos_r, ml, mm, mr); end
    if (bp > 0) begin
      bus.in_valid = 1'b1; bus.in_letter = 5'd7;
      for (int i = 0; i < bp; i++) begin
        tick();
        checks++;
        if (!bus.out_valid || bus.out_letter !== 5'(exp_out) || bus.in_ready)
          begin failures++; $display("FAIL backpressure_hold ov=%0d ol=%0d rdy=%0d exp=1/%0d/0", bus.out_valid, bus.out_letter, bus.in_ready, exp_out); end
      end
      bus.out_ready = 1'b1;
    end
    tick();
    checks++;
    if (bus.out_valid || !bus.in_ready)
      begin failures++; $display("FAIL handshake_release ov=%0d rdy=%0d exp=0/1", bus.out_valid, bus.in_ready); end
    last_acc = acc;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b1; bus.in_letter = 5'd3;
    tick(); tick(); tick();
    checks++;
    if ({bus.pos_l, bus.pos_m, bus.pos_r} !== {5'd1, 5'd1, 5'd1} || bus.out_valid !== 1'b0 ||
        bus.dp_start !== 1'b0 || bus.err !== 1'b0 || bus.out_letter !== 5'd0 || bus.dp_letter !== 5'd0)
      begin failures++; $display("FAIL reset_state pos=%0d/%0d/%0d ov=%0d ds=%0d err=%0d exp=1/1/1 0 0 0", bus.pos_l, bus.pos_m, bus.pos_r, bus.out_valid, bus.dp_start, bus.err); end
    bus.in_valid = 1'b0; rst = 1'b0;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0d exp=1", bus.in_ready); end
    ml = 1; mm = 1; mr = 1;
  endtask

  task automatic test_basic();
    send(4, 0, 0);
  endtask

  task automatic test_double_step();
    cfg(1, 4, 21);
    for (int i = 0; i < 4; i++) send($urandom_range(1, 26), 0, 0);
    checks++;
    if ({bus.pos_l, bus.pos_m, bus.pos_r} !== {5'd2, 5'd6, 5'd25})
      begin failures++; $display("FAIL double_step_end got=%0d/%0d/%0d exp=2/6/25", bus.pos_l, bus.pos_m, bus.pos_r); end
  endtask

  task automatic test_wrap();
    cfg(26, 5, 26);
    send(26, 0, 0);
    checks++;
    if ({bus.pos_l, bus.pos_m, bus.pos_r} !== {5'd1, 5'd6, 5'd1})
      begin failures++; $display("FAIL wrap got=%0d/%0d/%0d exp=1/6/1", bus.pos_l, bus.pos_m, bus.pos_r); end
  endtask

  task automatic test_back_to_back();
    int a1;
    send(10, 0, 0); a1 = last_acc;
    send(11, 0, 0);
    checks++;
    if (last_acc - a1 != DP_LAT + 4)
      begin failures++; $display("FAIL back_to_back_period got=%0d exp=%0d", last_acc - a1, DP_LAT + 4); end
  endtask

  task automatic test_backpressure();
    send(20, 5, 0);
    send(7, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 5) == 0) cfg($urandom_range(1, 26), $urandom_range(1, 26), $urandom_range(1, 26));
      send($urandom_range(1, 26), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, 0);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic test_cfg_during_wait();
    cfg(2, 9, 14);
    send(12, 0, 1);
  endtask

  task automatic test_errors();
    bit bad;
    bus.in_valid = 1'b1; bus.in_letter = 5'd0; tick();
    bus.in_letter = 5'd27; tick();
    bus.in_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin if (bus.dp_start) bad = 1; tick(); end
    checks++;
    if (bus.err !== 1'b1) begin failures++; $display("FAIL err_letter got=%0d exp=1", bus.err); end
    checks++;
    if (bad) begin failures++; $display("FAIL err_no_dp_start got=1 exp=0"); end
    checks++;
    if ({bus.pos_l, bus.pos_m, bus.pos_r} !== {5'(ml), 5'(mm), 5'(mr)})
      begin failures++; $display("FAIL err_pos got=%0d/%0d/%0d exp=%0d/%0d/%0d", bus.pos_l, bus.pos_m, bus.pos_r, ml, mm, mr); end
    rst = 1'b1; tick(); rst = 1'b0; tick();
    ml = 1; mm = 1; mr = 1;
    checks++;
    if (bus.err !== 1'b0) begin failures++; $display("FAIL err_clear got=%0d exp=0", bus.err); end
    cfg(0, 1, 1);
    cfg(5, 27, 3);
    tick();
    checks++;
    if (bus.err !== 1'b1 || {bus.pos_l, bus.pos_m, bus.pos_r} !== {5'd1, 5'd1, 5'd1})
      begin failures++; $display("FAIL err_cfg err=%0d pos=%0d/%0d/%0d exp=1 1/1/1", bus.err, bus.pos_l, bus.pos_m, bus.pos_r); end
    rst = 1'b1; tick(); rst = 1'b0; tick();
  endtask

  task automatic test_rst_abort();
    cfg(4, 4, 4);
    send(9, 0, 2);
    send(1, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.cfg_load = 1'b0; bus.cfg_pos_l = 5'd1; bus.cfg_pos_m = 5'd1; bus.cfg_pos_r = 5'd1;
    bus.in_valid = 1'b0; bus.in_letter = 5'd0; bus.out_ready = 1'b1;
    ml = 1; mm = 1; mr = 1; last_acc = 0;
    test_reset();
    test_basic();
    test_double_step();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_cfg_during_wait();
    test_errors();
    test_rst_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
